cla_adder_pipe: RTL and testbench

//   Parametrised, 2-stage pipelined carry-lookahead adder/subtractor. It generalises the fixed
//   16-bit ripple-of-groups carry unit to any WIDTH, using a two-level lookahead across groups.

---
 rtl/cla_adder_pipe_pkg.sv | 23 ++
 rtl/cla_group4.sv | 28 ++
 rtl/cla_adder_pipe.sv | 166 ++++++++++++++++
 tb/tb_cla_adder_pipe.sv | 174 +++++++++++++++++
 4 files changed

// File: rtl/cla_adder_pipe_pkg.sv
// Shared definitions for the pipelined carry-lookahead adder: group width,
// mode encodings and the group propagate/generate helper.
package cla_adder_pipe_pkg;

    localparam int GROUP_W = 4;

    localparam logic MODE_ADD = 1'b0;
    localparam logic MODE_SUB = 1'b1;

    typedef struct packed {
        logic pg;
        logic gg;
    } grp_la_t;

    function automatic grp_la_t group_lookahead(input logic [GROUP_W-1:0] p,
                                                input logic [GROUP_W-1:0] g);
        grp_la_t r;
        r.pg = &p;
        r.gg = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0]);
        return r;
    endfunction

endpackage

// File: rtl/cla_group4.sv
// 4-bit carry-lookahead unit: per-bit carries out from P/G/CI, plus group
// propagate/generate for the next lookahead level.
module cla_group4
    import cla_adder_pipe_pkg::*;
(
    input  logic [GROUP_W-1:0] p,
    input  logic [GROUP_W-1:0] g,
    input  logic               ci,
    output logic [GROUP_W-1:0] co,
    output logic               pg,
    output logic               gg
);

    grp_la_t la;

    always_comb begin
        co[0] = g[0] | (p[0] & ci);
        co[1] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & ci);
        co[2] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & ci);
        co[3] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
              | (p[3] & p[2] & p[1] & p[0] & ci);
    end

    assign la = group_lookahead(p, g);
    assign pg = la.pg;
    assign gg = la.gg;

endmodule

// File: rtl/cla_adder_pipe.sv
// Two-stage pipelined carry-lookahead adder/subtractor with valid/ready on both
// sides. Stage 1 forms P/G and group PG/GG; stage 2 resolves carries and flags.
module cla_adder_pipe
    import cla_adder_pipe_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int GROUP = GROUP_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             ci,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             co,
    output logic             ovf,
    output logic             zero
);

    localparam int NG = WIDTH / GROUP;
    localparam int NS = (NG + 3) / 4;

    logic             s2_adv, s1_adv, accept;
    logic [WIDTH-1:0] b_eff, p_in, g_in;
    logic             cin_in;
    logic [NG-1:0]    gpg_in, ggg_in;
    grp_la_t          la;

    logic             s1_valid;
    logic [WIDTH-1:0] s1_p, s1_g;
    logic             s1_cin;
    logic [NG-1:0]    s1_gpg, s1_ggg;

    assign s2_adv   = !out_valid | out_ready;
    assign s1_adv   = s1_valid & s2_adv;
    assign in_ready = !s1_valid | s2_adv;
    assign accept   = in_valid & in_ready;

    // Subtract is A + ~B + 1; the external carry-in is ignored in that mode.
    always_comb begin
        b_eff  = (sub == MODE_SUB) ? ~b : b;
        cin_in = (sub == MODE_ADD) ? ci : 1'b1;
        p_in   = a ^ b_eff;
        g_in   = a & b_eff;
        gpg_in = '0;
        ggg_in = '0;
        la     = '0;
        for (int k = 0; k < NG; k++) begin
            la        = group_lookahead(p_in[k*GROUP_W +: GROUP_W], g_in[k*GROUP_W +: GROUP_W]);
            gpg_in[k] = la.pg;
            ggg_in[k] = la.gg;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid <= 1'b0;
            s1_p     <= '0;
            s1_g     <= '0;
            s1_cin   <= 1'b0;
            s1_gpg   <= '0;
            s1_ggg   <= '0;
        end else begin
            if (in_ready)
                s1_valid <= in_valid;
            if (accept) begin
                s1_p   <= p_in;
                s1_g   <= g_in;
                s1_cin <= cin_in;
                s1_gpg <= gpg_in;
                s1_ggg <= ggg_in;
            end
        end
    end

    // Second level: group PG/GG padded to whole blocks of four groups.
    logic [4*NS-1:0] l2_pg_in, l2_gg_in, gc_out;
    logic [NS-1:0]   l2_pg_out, l2_gg_out;
    logic [NG-1:0]   grp_cin, grp_pg_out, grp_gg_out;
    logic [WIDTH-1:0] grp_co_all, s2_sum;
    logic            s2_co, s2_cmsb;

    always_comb begin
        l2_pg_in         = '0;
        l2_gg_in         = '0;
        l2_pg_in[NG-1:0] = s1_gpg;
        l2_gg_in[NG-1:0] = s1_ggg;
    end

    for (genvar j = 0; j < NS; j++) begin : g_l2
        logic       l2_ci;
        logic [3:0] l2_co;

        // Blocks chain through per-block wires so no vector feeds itself.
        if (j == 0) begin : g_first
            assign l2_ci = s1_cin;
        end else begin : g_next
            assign l2_ci = g_l2[j-1].l2_co[3];
        end

        cla_group4 u_l2 (
            .p  (l2_pg_in[4*j +: 4]),
            .g  (l2_gg_in[4*j +: 4]),
            .ci (l2_ci),
            .co (l2_co),
            .pg (l2_pg_out[j]),
            .gg (l2_gg_out[j])
        );

        assign gc_out[4*j +: 4] = l2_co;
    end

    always_comb begin
        grp_cin    = '0;
        grp_cin[0] = s1_cin;
        for (int k = 1; k < NG; k++)
            grp_cin[k] = gc_out[k-1];
    end

    for (genvar k = 0; k < NG; k++) begin : g_grp
        logic [GROUP_W-1:0] grp_co;

        cla_group4 u_grp (
            .p  (s1_p[k*GROUP_W +: GROUP_W]),
            .g  (s1_g[k*GROUP_W +: GROUP_W]),
            .ci (grp_cin[k]),
            .co (grp_co),
            .pg (grp_pg_out[k]),
            .gg (grp_gg_out[k])
        );

        assign s2_sum[k*GROUP_W +: GROUP_W]     = s1_p[k*GROUP_W +: GROUP_W] ^ {grp_co[2:0], grp_cin[k]};
        assign grp_co_all[k*GROUP_W +: GROUP_W] = grp_co;
    end

    assign s2_co   = grp_co_all[WIDTH-1];
    assign s2_cmsb = grp_co_all[WIDTH-2];

    // Redundant lookahead outputs (top-level PG/GG, padded carries) are not needed.
    logic unused_la;
    assign unused_la = ^{grp_co_all, gc_out, l2_pg_out, l2_gg_out, grp_pg_out, grp_gg_out};

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
            sum       <= '0;
            co        <= 1'b0;
            ovf       <= 1'b0;
            zero      <= 1'b0;
        end else if (s2_adv) begin
            out_valid <= s1_valid;
            if (s1_adv) begin
                sum  <= s2_sum;
                co   <= s2_co;
                ovf  <= s2_co ^ s2_cmsb;
                zero <= (s2_sum == '0);
            end
        end
    end

endmodule

// File: tb/tb_cla_adder_pipe.sv
// Directed bench for cla_adder_pipe: arithmetic vectors, flags, back-to-back
// streaming, output stall, reset with operations in flight, 32-bit carry chain.
module tb_cla_adder_pipe;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid, in_ready, ci, sub, out_valid, out_ready, co, ovf, zero;
    logic [15:0] a, b, sum;

    logic        in_valid32, in_ready32, ci32, sub32, out_valid32, co32, ovf32, zero32;
    logic        out_ready32;
    logic [31:0] a32, b32, sum32;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    cla_adder_pipe #(.WIDTH(16)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .ci(ci), .sub(sub), .out_valid(out_valid), .out_ready(out_ready),
        .sum(sum), .co(co), .ovf(ovf), .zero(zero)
    );

    cla_adder_pipe #(.WIDTH(32)) dut32 (
        .clk(clk), .rst(rst), .in_valid(in_valid32), .in_ready(in_ready32),
        .a(a32), .b(b32), .ci(ci32), .sub(sub32), .out_valid(out_valid32), .out_ready(out_ready32),
        .sum(sum32), .co(co32), .ovf(ovf32), .zero(zero32)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp)
            n_pass++;
        else
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic run_one(input string tag, input logic [15:0] ta, input logic [15:0] tb_v,
                           input logic tci, input logic tsub, input logic [15:0] esum,
                           input logic eco, input logic eovf, input logic ezero);
        a = ta; b = tb_v; ci = tci; sub = tsub; in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        step();
        check({tag, "_valid"}, 32'(out_valid), 32'd1);
        check({tag, "_sum"},   32'(sum),       32'(esum));
        check({tag, "_co"},    32'(co),        32'(eco));
        check({tag, "_ovf"},   32'(ovf),       32'(eovf));
        check({tag, "_zero"},  32'(zero),      32'(ezero));
        step();
        check({tag, "_retired"}, 32'(out_valid), 32'd0);
    endtask

    logic [15:0] t4_a   [8] = '{16'h0001, 16'h00FF, 16'h1000, 16'hFFFF, 16'h0F0F, 16'h0000, 16'h8000, 16'h1234};
    logic [15:0] t4_b   [8] = '{16'h0002, 16'h0001, 16'h0001, 16'hFFFF, 16'hF0F0, 16'h0001, 16'h0001, 16'h4321};
    logic        t4_ci  [8] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
    logic        t4_sub [8] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
    logic [15:0] t4_sum [8] = '{16'h0003, 16'h0100, 16'h0FFF, 16'hFFFE, 16'h0000, 16'hFFFF, 16'h7FFF, 16'h5556};
    logic        t4_co  [8] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0};

    initial begin
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
        a = '0; b = '0; ci = 1'b0; sub = 1'b0;
        in_valid32 = 1'b0; out_ready32 = 1'b1; a32 = '0; b32 = '0; ci32 = 1'b0; sub32 = 1'b0;
        step();
        step();
        rst = 1'b0;
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_sum",       32'(sum),       32'd0);
        check("rst_flags",     32'({co, ovf, zero}), 32'd0);
        check("rst_in_ready",  32'(in_ready),  32'd1);

        run_one("add_ovf",    16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1, 1'b0);
        run_one("sub_eq",     16'h0005, 16'h0005, 1'b1, 1'b1, 16'h0000, 1'b1, 1'b0, 1'b1);
        run_one("chain16",    16'hFFFF, 16'h0000, 1'b1, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b1);
        run_one("sub_borrow", 16'h0000, 16'h0001, 1'b0, 1'b1, 16'hFFFF, 1'b0, 1'b0, 1'b0);
        run_one("sub_ovf",    16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b1, 1'b0);
        run_one("add_negovf", 16'h8000, 16'h8000, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b1, 1'b1);

        // 32-bit instance: carry across the 16-bit lookahead block boundary
        a32 = 32'hFFFF_FFFF; b32 = 32'h0; ci32 = 1'b1; sub32 = 1'b0; in_valid32 = 1'b1;
        step();
        a32 = 32'h0000_FFFF; b32 = 32'h1; ci32 = 1'b0;
        step();
        check("w32_chain_valid", 32'(out_valid32), 32'd1);
        check("w32_chain_sum",   sum32,            32'h0);
        check("w32_chain_co",    32'(co32),        32'd1);
        check("w32_chain_zero",  32'(zero32),      32'd1);
        a32 = 32'h0; b32 = 32'h1; sub32 = 1'b1;
        step();
        in_valid32 = 1'b0;
        check("w32_blk_sum", sum32,     32'h0001_0000);
        check("w32_blk_co",  32'(co32), 32'd0);
        step();
        check("w32_sub_sum", sum32,     32'hFFFF_FFFF);
        check("w32_sub_co",  32'(co32), 32'd0);

        // back-to-back stream
        for (int c = 0; c < 9; c++) begin
            if (c < 8) begin
                a = t4_a[c]; b = t4_b[c]; ci = t4_ci[c]; sub = t4_sub[c]; in_valid = 1'b1;
                check($sformatf("b2b_in_ready%0d", c), 32'(in_ready), 32'd1);
            end else begin
                in_valid = 1'b0;
            end
            step();
            if (c >= 1) begin
                check($sformatf("b2b_valid%0d", c - 1), 32'(out_valid), 32'd1);
                check($sformatf("b2b_sum%0d", c - 1),   32'(sum),       32'(t4_sum[c-1]));
                check($sformatf("b2b_co%0d", c - 1),    32'(co),        32'(t4_co[c-1]));
            end
        end
        step();
        check("b2b_drained", 32'(out_valid), 32'd0);

        // output stall
        out_ready = 1'b0; ci = 1'b0; sub = 1'b0;
        a = 16'h0011; b = 16'h0022; in_valid = 1'b1;
        check("stall_rdy_a", 32'(in_ready), 32'd1);
        step();
        a = 16'h0100; b = 16'h0200;
        check("stall_rdy_b", 32'(in_ready), 32'd1);
        step();
        for (int i = 0; i < 3; i++) begin
            a = 16'h7777; b = 16'h1111;
            check($sformatf("stall_in_ready%0d", i), 32'(in_ready),  32'd0);
            check($sformatf("stall_valid%0d", i),    32'(out_valid), 32'd1);
            check($sformatf("stall_sum%0d", i),      32'(sum),       32'h0033);
            step();
        end
        check("stall_hold_sum", 32'(sum), 32'h0033);
        in_valid = 1'b0; out_ready = 1'b1;
        step();
        check("release_valid_b", 32'(out_valid), 32'd1);
        check("release_sum_b",   32'(sum),       32'h0300);
        step();
        check("release_empty",  32'(out_valid), 32'd0);
        step();
        check("release_no_dup", 32'(out_valid), 32'd0);
        check("release_no_c",   32'(sum),       32'h0300);

        // reset with two operations in flight
        out_ready = 1'b0;
        a = 16'h7FFF; b = 16'h0001; in_valid = 1'b1;
        step();
        a = 16'h0005; b = 16'h0003;
        step();
        in_valid = 1'b0;
        check("inflight_valid", 32'(out_valid), 32'd1);
        check("inflight_ovf",   32'(ovf),       32'd1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("midrst_valid",    32'(out_valid), 32'd0);
        check("midrst_sum",      32'(sum),       32'd0);
        check("midrst_flags",    32'({co, ovf, zero}), 32'd0);
        check("midrst_in_ready", 32'(in_ready),  32'd1);
        out_ready = 1'b1;
        step();
        check("midrst_gone1", 32'(out_valid), 32'd0);
        step();
        check("midrst_gone2", 32'(out_valid), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
